// File: rtl/fetch_unit_if.sv
// fetch_unit_if: bundles the instruction-memory handshake and the decode-side
// delivery signals of the fetch stage. The fetch unit uses the master view;
// memory, decode and execute together form the slave view.
interface fetch_unit_if;
    // redirect from execute
    logic        is_branch;
    logic [31:0] PC_add_imm;
    // decode back-pressure
    logic        stall;
    // instruction memory request/response
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    // queue head presented to decode
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] PC_number;

    modport master (
        input  is_branch, PC_add_imm, stall, imem_ready, imem_rvalid, imem_rdata,
        output imem_req, imem_addr, inst_valid, inst, PC_number
    );

    modport slave (
        output is_branch, PC_add_imm, stall, imem_ready, imem_rvalid, imem_rdata,
        input  imem_req, imem_addr, inst_valid, inst, PC_number
    );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage. Keeps the PC, issues one word fetch at a
// time to instruction memory, queues returned words with their PCs and flushes
// everything on a branch redirect from execute.
// Optional feature: define FETCH_PERF_EN to add the perf_fetched / perf_flushed
// counter outputs.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 2
) (
    input  logic             clk,
    input  logic             rst,
    fetch_unit_if.master     bus
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]      perf_fetched,
    output logic [31:0]      perf_flushed
`endif
);

    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(QDEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DROP
    } state_t;

    state_t          state;
    logic [31:0]     pc;
    logic [31:0]     req_pc;
    logic [CW-1:0]   count;
    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;
    logic [31:0]     q_inst [QDEPTH];
    logic [31:0]     q_pc   [QDEPTH];

    logic            accept;
    logic            push;
    logic            pop;

    // A request is only offered when idle with a guaranteed free slot, and
    // never in a redirect cycle so a wrong-path address is not accepted.
    assign bus.imem_req  = !rst && (state == S_IDLE) && (count < DEPTH_C) && !bus.is_branch;
    assign bus.imem_addr = pc;

    assign accept = bus.imem_req && bus.imem_ready;
    assign push   = (state == S_WAIT) && bus.imem_rvalid && !bus.is_branch;
    assign pop    = (count != '0) && !bus.stall && !bus.is_branch;

    assign bus.inst_valid = (count != '0);
    assign bus.inst       = q_inst[head];
    assign bus.PC_number  = q_pc[head];

    // Fetch control: PC, outstanding-request state, queue occupancy and pointers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            pc     <= RESET_PC;
            req_pc <= '0;
            count  <= '0;
            head   <= '0;
            tail   <= '0;
        end else if (bus.is_branch) begin
            pc    <= {bus.PC_add_imm[31:2], 2'b00};
            count <= '0;
            head  <= '0;
            tail  <= '0;
            case (state)
                S_WAIT:  state <= bus.imem_rvalid ? S_IDLE : S_DROP;
                S_DROP:  state <= bus.imem_rvalid ? S_IDLE : S_DROP;
                default: state <= S_IDLE;
            endcase
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        state  <= S_WAIT;
                        req_pc <= pc;
                        pc     <= pc + 32'd4;
                    end
                end
                S_WAIT: begin
                    if (bus.imem_rvalid) begin
                        state <= S_IDLE;
                    end
                end
                S_DROP: begin
                    if (bus.imem_rvalid) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
            if (push) begin
                tail <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    // Queue storage: write the returned word and its PC at the tail slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < QDEPTH; i++) begin
                q_inst[i] <= '0;
                q_pc[i]   <= '0;
            end
        end else if (push) begin
            q_inst[tail] <= bus.imem_rdata;
            q_pc[tail]   <= req_pc;
        end
    end

`ifdef FETCH_PERF_EN
    // Performance counters: accepted fetches, and instructions thrown away by
    // redirects (queued entries plus the response still owed in WAIT).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetched <= '0;
            perf_flushed <= '0;
        end else begin
            if (accept) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            if (bus.is_branch) begin
                perf_flushed <= perf_flushed + 32'(count) + {31'b0, (state == S_WAIT)};
            end
        end
    end
`endif

endmodule
